stage_tl: RTL
=============

Name: stage_tl

Overview:
- Pipeline stage directly downstream of the execute stage.
- Performs the data-TLB lookup for loads and stores and holds the DTLB contents.
- Services TLB-write instructions for both the DTLB and the ITLB.
- Registers everything into the TL/cache pipeline register consumed by the cache stage.

Parameters:
- DTLB_ENTRIES, 4, number of fully associative DTLB entries (power of 2, >=2)
- VPN_BITS, 20, virtual page number width (4 KiB pages, vaddr[31:12])
- PPN_BITS, 8, physical page number width; physical address = PPN_BITS+12 bits
- THREAD_BITS, 2, width of threadid_t

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold pipeline register and DTLB state
- flush  in  1  kill instruction entering the register this cycle
- ex_thread  in  THREAD_BITS  thread of incoming instruction
- ex_isvalid, ex_itlb_miss  in  1 each  validity, fetch-side miss flag
- ex_pc  in  32  instruction virtual PC
- ex_data  in  32  ALU result; virtual address for memory ops
- ex_mul  in  32  multiplier result
- ex_r2  in  32  store data / PPN source for TLB writes
- ex_dst  in  5  destination register
- ex_isequal  in  1  r1==r2 compare result
- ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret  in  1 each  decoded flags
- ex_flag_tlbwrite  in  tlbwrite_t  none / itlb / dtlb
- ex_rm4  in  32  privilege word; bit 0 = supervisor
- c_thread, c_isvalid, c_itlb_miss, c_pc, c_r2, c_dst, c_isequal, c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_reg, c_flag_jump, c_flag_branch, c_flag_iret, c_rm4  out  same widths  registered pass-through
- c_data  out  32  ex_flag_mul ? ex_mul : ex_data, registered
- c_paddr  out  PPN_BITS+12  translated physical address
- c_dtlb_miss  out  1  DTLB miss on a user-mode memory op
- itlb_wr_en  out  1  one-cycle ITLB write strobe
- itlb_wr_vpn  out  VPN_BITS  ITLB write tag
- itlb_wr_ppn  out  PPN_BITS  ITLB write data

Behaviour:
- Latency 1 cycle: inputs sampled at posedge appear on c_* after that edge.
- Reset:
  - all c_* = 0 and c_dtlb_miss = 0.
  - itlb_wr_en = 0.
  - every DTLB entry invalid; replacement pointer = 0.
- DTLB entry fields: valid, thread, VPN, PPN.
- Hit condition: entry valid, entry.thread == ex_thread, and entry.VPN == ex_data[31:12]. At most one entry hits.
- Translation (combinational on inputs, then registered):
  - Supervisor (ex_rm4[0]=1): c_paddr = ex_data[PPN_BITS+11:0] (bypass); miss = 0.
  - User with hit: c_paddr = {entry.PPN, ex_data[11:0]}.
  - User with no hit: c_paddr = 0; c_dtlb_miss = ex_isvalid & ex_flag_mem & ~ex_itlb_miss.
  - Non-memory ops always give c_dtlb_miss = 0.
- A miss does not clear c_isvalid; the exception is taken downstream.
- TLB write is accepted when ex_isvalid & ~ex_itlb_miss & ex_rm4[0] & ~stall & ~flush. Ignored otherwise, including in user mode.
- dtlb write:
  - Fields: VPN = ex_data[31:12], PPN = ex_r2[PPN_BITS-1:0], thread = ex_thread.
  - If a valid entry of the same thread already has that VPN, it is overwritten and the pointer does not advance.
  - Otherwise the write goes to the pointer slot, and the pointer advances mod DTLB_ENTRIES (round-robin, wraps).
  - The new entry is visible to lookups in the next cycle.
- itlb write: same VPN/PPN extraction; itlb_wr_en pulses high for exactly one cycle after the accept edge. DTLB is untouched.
- stall=1: all c_* outputs, itlb_wr_en, DTLB entries and pointer hold; no write is accepted.
- flush=1 without stall: c_isvalid and c_dtlb_miss register 0; other fields load normally; no TLB write.
- stall and flush together: stall wins.
- itlb_wr_en is forced to 0 on any cycle it is not freshly set.
- rst dominates stall and flush; a reset mid-stall clears state on that edge.

Test Plan:
- Reset, then a user-mode load (rm4=0, thread 1, vaddr 0x00003ABC) -> c_isvalid=1, c_dtlb_miss=1, c_paddr=0.
- Supervisor dtlb write (vaddr 0x00003000, r2=0x5A, thread 1), then the same load next cycle -> c_dtlb_miss=0, c_paddr=0x5AABC. The same load from thread 2 -> miss.
- Five distinct supervisor dtlb writes with VPNs 1..5 -> VPN 5 lands in slot 0 (wrap). A lookup of VPN 1 misses; VPN 2 hits. Rewriting VPN 3 with a new PPN updates in place, and the next new VPN goes to slot 1.
- User-mode dtlb write, and a supervisor write with ex_itlb_miss=1 -> DTLB unchanged; the next lookup still misses.
- Supervisor itlb write (vaddr 0x00007000, r2=0x12) -> itlb_wr_en=1 for one cycle, itlb_wr_vpn=0x00007, itlb_wr_ppn=0x12; DTLB lookup of VPN 7 misses.
- stall held 3 cycles with a changing input -> c_* constant. flush with a dtlb write -> c_isvalid=0 and no entry written. ex_flag_mul=1 with mul=0xDEADBEEF -> c_data=0xDEADBEEF.

Source files
------------

// File: rtl/stage_tl_if.sv
// Shared TLB-write type and the EX -> TL -> cache bundle.
// Upstream side (execute stage) is the master; stage_tl is the slave.
package stage_tl_pkg;
    typedef enum logic [1:0] {
        TLBW_NONE = 2'd0,
        TLBW_ITLB = 2'd1,
        TLBW_DTLB = 2'd2
    } tlbwrite_t;
endpackage

interface stage_tl_if #(
    parameter int VPN_BITS    = 20,
    parameter int PPN_BITS    = 8,
    parameter int THREAD_BITS = 2
);
    import stage_tl_pkg::*;

    logic [THREAD_BITS-1:0] ex_thread;
    logic                   ex_isvalid;
    logic                   ex_itlb_miss;
    logic [31:0]            ex_pc;
    logic [31:0]            ex_data;
    logic [31:0]            ex_mul;
    logic [31:0]            ex_r2;
    logic [4:0]             ex_dst;
    logic                   ex_isequal;
    logic                   ex_flag_mem;
    logic                   ex_flag_store;
    logic                   ex_flag_isbyte;
    logic                   ex_flag_mul;
    logic                   ex_flag_reg;
    logic                   ex_flag_jump;
    logic                   ex_flag_branch;
    logic                   ex_flag_iret;
    tlbwrite_t              ex_flag_tlbwrite;
    logic [31:0]            ex_rm4;

    logic [THREAD_BITS-1:0] c_thread;
    logic                   c_isvalid;
    logic                   c_itlb_miss;
    logic [31:0]            c_pc;
    logic [31:0]            c_data;
    logic [31:0]            c_r2;
    logic [4:0]             c_dst;
    logic                   c_isequal;
    logic                   c_flag_mem;
    logic                   c_flag_store;
    logic                   c_flag_isbyte;
    logic                   c_flag_reg;
    logic                   c_flag_jump;
    logic                   c_flag_branch;
    logic                   c_flag_iret;
    logic [31:0]            c_rm4;
    logic [PPN_BITS+11:0]   c_paddr;
    logic                   c_dtlb_miss;

    logic                   itlb_wr_en;
    logic [VPN_BITS-1:0]    itlb_wr_vpn;
    logic [PPN_BITS-1:0]    itlb_wr_ppn;

    modport master (
        output ex_thread, ex_isvalid, ex_itlb_miss, ex_pc, ex_data, ex_mul, ex_r2,
               ex_dst, ex_isequal, ex_flag_mem, ex_flag_store, ex_flag_isbyte,
               ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret,
               ex_flag_tlbwrite, ex_rm4,
        input  c_thread, c_isvalid, c_itlb_miss, c_pc, c_data, c_r2, c_dst, c_isequal,
               c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_reg, c_flag_jump,
               c_flag_branch, c_flag_iret, c_rm4, c_paddr, c_dtlb_miss,
               itlb_wr_en, itlb_wr_vpn, itlb_wr_ppn
    );

    modport slave (
        input  ex_thread, ex_isvalid, ex_itlb_miss, ex_pc, ex_data, ex_mul, ex_r2,
               ex_dst, ex_isequal, ex_flag_mem, ex_flag_store, ex_flag_isbyte,
               ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret,
               ex_flag_tlbwrite, ex_rm4,
        output c_thread, c_isvalid, c_itlb_miss, c_pc, c_data, c_r2, c_dst, c_isequal,
               c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_reg, c_flag_jump,
               c_flag_branch, c_flag_iret, c_rm4, c_paddr, c_dtlb_miss,
               itlb_wr_en, itlb_wr_vpn, itlb_wr_ppn
    );
endinterface

// File: rtl/stage_tl.sv
// TL stage: fully associative DTLB lookup, DTLB/ITLB write service, and the
// TL/cache pipeline register.
module stage_tl
    import stage_tl_pkg::*;
#(
    parameter int DTLB_ENTRIES = 4,
    parameter int VPN_BITS     = 20,
    parameter int PPN_BITS     = 8,
    parameter int THREAD_BITS  = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      flush,
    stage_tl_if.slave bus
);
    localparam int PTR_W = $clog2(DTLB_ENTRIES);
    localparam int PA_W  = PPN_BITS + 12;

    logic [DTLB_ENTRIES-1:0] r_ent_vld;
    logic [THREAD_BITS-1:0]  r_ent_thr [DTLB_ENTRIES];
    logic [VPN_BITS-1:0]     r_ent_vpn [DTLB_ENTRIES];
    logic [PPN_BITS-1:0]     r_ent_ppn [DTLB_ENTRIES];
    logic [PTR_W-1:0]        r_ptr;

    logic [VPN_BITS-1:0]     w_vpn;
    logic [PPN_BITS-1:0]     w_wr_ppn;
    logic                    w_sup;
    logic                    w_hit;
    logic [PPN_BITS-1:0]     w_hit_ppn;
    logic [PTR_W-1:0]        w_hit_idx;
    logic [PTR_W-1:0]        w_wr_idx;
    logic                    w_accept;
    logic                    w_dtlb_wr;
    logic                    w_itlb_wr;
    logic [PA_W-1:0]         w_paddr;
    logic                    w_miss;

    assign w_vpn    = bus.ex_data[31:12];
    assign w_wr_ppn = bus.ex_r2[PPN_BITS-1:0];
    assign w_sup    = bus.ex_rm4[0];

    // A lookup hit and a same-tag write match are the same condition, so one
    // compare bank serves both the translation and in-place overwrite.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_ppn = '0;
        w_hit_idx = '0;
        for (int i = 0; i < DTLB_ENTRIES; i++) begin
            if (r_ent_vld[i] && (r_ent_thr[i] == bus.ex_thread) && (r_ent_vpn[i] == w_vpn)) begin
                w_hit     = 1'b1;
                w_hit_ppn = r_ent_ppn[i];
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    assign w_accept  = bus.ex_isvalid & ~bus.ex_itlb_miss & w_sup & ~stall & ~flush;
    assign w_dtlb_wr = w_accept & (bus.ex_flag_tlbwrite == TLBW_DTLB);
    assign w_itlb_wr = w_accept & (bus.ex_flag_tlbwrite == TLBW_ITLB);
    assign w_wr_idx  = w_hit ? w_hit_idx : r_ptr;

    always_comb begin
        w_paddr = '0;
        if (w_sup)
            w_paddr = bus.ex_data[PA_W-1:0];
        else if (w_hit)
            w_paddr = {w_hit_ppn, bus.ex_data[11:0]};
    end

    assign w_miss = ~flush & ~w_sup & ~w_hit & bus.ex_isvalid & bus.ex_flag_mem & ~bus.ex_itlb_miss;

    // DTLB control state: valid bits and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent_vld <= '0;
            r_ptr     <= '0;
        end else if (w_dtlb_wr) begin
            r_ent_vld[w_wr_idx] <= 1'b1;
            if (!w_hit)
                r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_dtlb_wr) begin
            r_ent_thr[w_wr_idx] <= bus.ex_thread;
            r_ent_vpn[w_wr_idx] <= w_vpn;
            r_ent_ppn[w_wr_idx] <= w_wr_ppn;
        end
    end

    // ITLB write port: strobe is only high the cycle after an accepted write
    logic                r_itlb_en_p1;
    logic [VPN_BITS-1:0] r_itlb_vpn_p1;
    logic [PPN_BITS-1:0] r_itlb_ppn_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_itlb_en_p1  <= 1'b0;
            r_itlb_vpn_p1 <= '0;
            r_itlb_ppn_p1 <= '0;
        end else if (!stall) begin
            r_itlb_en_p1 <= w_itlb_wr;
            if (w_itlb_wr) begin
                r_itlb_vpn_p1 <= w_vpn;
                r_itlb_ppn_p1 <= w_wr_ppn;
            end
        end
    end

    // TL/cache pipeline register
    logic [THREAD_BITS-1:0] r_thread_p1;
    logic                   r_isvalid_p1;
    logic                   r_itlb_miss_p1;
    logic [31:0]            r_pc_p1;
    logic [31:0]            r_data_p1;
    logic [31:0]            r_r2_p1;
    logic [4:0]             r_dst_p1;
    logic                   r_isequal_p1;
    logic [6:0]             r_flags_p1;
    logic [31:0]            r_rm4_p1;
    logic [PA_W-1:0]        r_paddr_p1;
    logic                   r_miss_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thread_p1    <= '0;
            r_isvalid_p1   <= 1'b0;
            r_itlb_miss_p1 <= 1'b0;
            r_pc_p1        <= '0;
            r_data_p1      <= '0;
            r_r2_p1        <= '0;
            r_dst_p1       <= '0;
            r_isequal_p1   <= 1'b0;
            r_flags_p1     <= '0;
            r_rm4_p1       <= '0;
            r_paddr_p1     <= '0;
            r_miss_p1      <= 1'b0;
        end else if (!stall) begin
            r_thread_p1    <= bus.ex_thread;
            r_isvalid_p1   <= bus.ex_isvalid & ~flush;
            r_itlb_miss_p1 <= bus.ex_itlb_miss;
            r_pc_p1        <= bus.ex_pc;
            r_data_p1      <= bus.ex_flag_mul ? bus.ex_mul : bus.ex_data;
            r_r2_p1        <= bus.ex_r2;
            r_dst_p1       <= bus.ex_dst;
            r_isequal_p1   <= bus.ex_isequal;
            r_flags_p1     <= {bus.ex_flag_mem, bus.ex_flag_store, bus.ex_flag_isbyte,
                               bus.ex_flag_reg, bus.ex_flag_jump, bus.ex_flag_branch,
                               bus.ex_flag_iret};
            r_rm4_p1       <= bus.ex_rm4;
            r_paddr_p1     <= w_paddr;
            r_miss_p1      <= w_miss;
        end
    end

    assign bus.c_thread      = r_thread_p1;
    assign bus.c_isvalid     = r_isvalid_p1;
    assign bus.c_itlb_miss   = r_itlb_miss_p1;
    assign bus.c_pc          = r_pc_p1;
    assign bus.c_data        = r_data_p1;
    assign bus.c_r2          = r_r2_p1;
    assign bus.c_dst         = r_dst_p1;
    assign bus.c_isequal     = r_isequal_p1;
    assign bus.c_flag_mem    = r_flags_p1[6];
    assign bus.c_flag_store  = r_flags_p1[5];
    assign bus.c_flag_isbyte = r_flags_p1[4];
    assign bus.c_flag_reg    = r_flags_p1[3];
    assign bus.c_flag_jump   = r_flags_p1[2];
    assign bus.c_flag_branch = r_flags_p1[1];
    assign bus.c_flag_iret   = r_flags_p1[0];
    assign bus.c_rm4         = r_rm4_p1;
    assign bus.c_paddr       = r_paddr_p1;
    assign bus.c_dtlb_miss   = r_miss_p1;
    assign bus.itlb_wr_en    = r_itlb_en_p1;
    assign bus.itlb_wr_vpn   = r_itlb_vpn_p1;
    assign bus.itlb_wr_ppn   = r_itlb_ppn_p1;
endmodule
